mdu: RTL

Multiply/divide unit for the five-stage MIPS pipeline, sitting in the E stage beside the ALU. Executes the MDUOp commands and Start strobe produced by the control unit: mult, multu, div, divu, mfhi, mflo, mthi, mtlo. Holds the architectural HI/LO registers and exposes Busy so the hazard unit can stall later MDU instructions in D.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_if.sv | 37 +++
 rtl/mdu.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: command encodings and default latencies.
// Also used by the control unit when it builds MDUOp.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  function automatic logic mdu_is_signed(
    input mdu_op_e op
  );
    return (op == MDU_MULT) ||
           (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage command/result bundle between the
// control/forwarding side and the MDU.
interface mdu_if;
  import mdu_pkg::*;

  mdu_op_e     MDUOp;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  modport master (
    output MDUOp,
    output Start,
    output A,
    output B,
    input  Busy,
    input  HI,
    input  LO,
    input  MDUOut
  );

  modport slave (
    input  MDUOp,
    input  Start,
    input  A,
    input  B,
    output Busy,
    output HI,
    output LO,
    output MDUOut
  );

endinterface

// File: rtl/mdu.sv
// Multiply/divide unit: HI/LO registers, pending result
// computed at Start and committed when the countdown expires.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input logic  clk,
  input logic  reset_n,
  mdu_if.slave bus
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] MULT_LD =
    CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD =
    CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE =
    CW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic        go;
  logic        is_mul;
  logic        is_div;
  logic        is_mthi;
  logic        is_mtlo;
  logic        sgn;

  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] abs_a, abs_b;
  logic [31:0] uq, ur;
  logic [31:0] quo, rem;
  logic [31:0] mdu_out;

  always_comb begin
    go      = bus.Start &&
              (state_q == S_IDLE);
    sgn     = mdu_is_signed(bus.MDUOp);
    is_mul  = go &&
              ((bus.MDUOp == MDU_MULT) ||
               (bus.MDUOp == MDU_MULTU));
    is_div  = go &&
              ((bus.MDUOp == MDU_DIV) ||
               (bus.MDUOp == MDU_DIVU));
    is_mthi = go && (bus.MDUOp == MDU_MTHI);
    is_mtlo = go && (bus.MDUOp == MDU_MTLO);
  end

  // One 64x64 multiplier serves both signednesses
  // via operand extension; low 64 bits are exact.
  always_comb begin
    mul_a = {{32{sgn & bus.A[31]}}, bus.A};
    mul_b = {{32{sgn & bus.B[31]}}, bus.B};
    prod  = mul_a * mul_b;
  end

  // Divide magnitudes, then restore signs; this keeps
  // 0x80000000 / -1 well defined (wraps to 0x80000000).
  always_comb begin
    abs_a = (sgn && bus.A[31]) ?
            (32'd0 - bus.A) : bus.A;
    abs_b = (sgn && bus.B[31]) ?
            (32'd0 - bus.B) : bus.B;
    uq = '0;
    ur = '0;
    if (abs_b != '0) begin
      uq = abs_a / abs_b;
      ur = abs_a % abs_b;
    end
    quo = (sgn && (bus.A[31] ^ bus.B[31])) ?
          (32'd0 - uq) : uq;
    rem = (sgn && bus.A[31]) ?
          (32'd0 - ur) : ur;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          is_mul: begin
            pend_d  = prod;
            cnt_d   = MULT_LD;
            state_d = S_RUN;
          end
          is_div: begin
            pend_d  = (bus.B == '0) ?
                      {hi_q, lo_q} :
                      {rem, quo};
            cnt_d   = DIV_LD;
            state_d = S_RUN;
          end
          is_mthi: hi_d = bus.A;
          is_mtlo: lo_d = bus.A;
          default: ;
        endcase
      end
      default: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          {hi_d, lo_d} = pend_q;
          state_d      = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    mdu_out = '0;
    unique case (bus.MDUOp)
      MDU_MFHI: mdu_out = hi_q;
      MDU_MFLO: mdu_out = lo_q;
      default:  ;
    endcase
  end

  assign bus.Busy   = (cnt_q != '0);
  assign bus.HI     = hi_q;
  assign bus.LO     = lo_q;
  assign bus.MDUOut = mdu_out;

endmodule
